// File: rtl/nvdla_fifo_pkg.sv
// Shared helpers for the parametrised SDP queue: width functions and write-side state type.
package nvdla_fifo_pkg;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Address width for a given depth.
  function automatic int unsigned aw_of(input int unsigned depth);
    return clog2(depth);
  endfunction

  // Count width able to hold 0..depth.
  function automatic int unsigned cw_of(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

  localparam int unsigned MAX_DEPTH = 1024;
  localparam int unsigned MAX_CW    = cw_of(MAX_DEPTH);

  // Write-side occupancy and push-blocking flag, sized for the largest legal depth.
  typedef struct packed {
    logic [MAX_CW-1:0] count;
    logic              busy;
  } wr_state_t;

endpackage

// File: rtl/nvdla_fifo_ram_2p.sv
// Two-port RAM: one write port, one synchronous read port with 1-cycle latency.
module nvdla_fifo_ram_2p
  import nvdla_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 80
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [aw_of(DEPTH)-1:0]    wa,
  input  logic [WIDTH-1:0]           di,
  input  logic                       re,
  input  logic                       ore,
  input  logic [aw_of(DEPTH)-1:0]    ra,
  output logic [WIDTH-1:0]           dout,
  input  logic [31:0]                pwrbus_ram_pd
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;
  logic             unused_pwrbus;

  // Power-down controls only matter to a hard macro; the behavioural array ignores them.
  assign unused_pwrbus = ^pwrbus_ram_pd;

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
  end

  // Registered read; output holds whenever the read is not enabled.
  always_ff @(posedge clk) begin
    if (re && ore) rd_q <= mem[ra];
  end

  assign dout = rd_q;

endmodule

// File: rtl/nvdla_sdp_param_cq.sv
// Parametrised SDP command/data queue with valid/ready ports, runtime limit, afull and flush.
module nvdla_sdp_param_cq
  import nvdla_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 80
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rst,
  input  logic                       in_pvld,
  output logic                       in_prdy,
  input  logic [WIDTH-1:0]           in_pd,
  output logic                       out_pvld,
  input  logic                       out_prdy,
  output logic [WIDTH-1:0]           out_pd,
  input  logic [cw_of(DEPTH)-1:0]    cfg_wr_limit,
  input  logic [cw_of(DEPTH)-1:0]    cfg_afull_thresh,
  input  logic                       flush,
  output logic [cw_of(DEPTH)-1:0]    wr_count,
  output logic                       afull,
  input  logic [31:0]                pwrbus_ram_pd
);

  localparam int unsigned AW = aw_of(DEPTH);
  localparam int unsigned CW = cw_of(DEPTH);

  wr_state_t         wr_q, wr_d;
  logic [AW-1:0]     wr_adr_q, wr_adr_d;
  logic              wr_popping_q;
  logic              afull_q, afull_d;
  logic              rd_pushing_q;
  logic [AW-1:0]     rd_adr_q, rd_adr_d;
  logic [CW-1:0]     rd_count_q, rd_count_d;
  logic              out_pvld_q, out_pvld_d;
  logic              wr_pushing;
  logic              rd_popping;
  logic              ram_we;
  logic              ram_re;
  logic [AW-1:0]     ram_ra;

  // Pointer increment wrapping at DEPTH-1, so non-power-of-two depths work.
  function automatic logic [AW-1:0] adr_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  assign wr_pushing = in_pvld & ~wr_q.busy;
  assign rd_popping = out_pvld_q & out_prdy;
  assign ram_we     = wr_pushing & ~flush;

  // Write side: occupancy sees pops one cycle late; busy and afull look at the next count.
  always_comb begin
    wr_d       = '0;
    wr_adr_d   = wr_adr_q;
    afull_d    = 1'b0;
    wr_d.count = wr_q.count + MAX_CW'(wr_pushing) - MAX_CW'(wr_popping_q);
    wr_d.busy  = (wr_d.count == MAX_CW'(DEPTH)) ||
                 ((cfg_wr_limit != '0) && (wr_d.count >= MAX_CW'(cfg_wr_limit)));
    afull_d    = (wr_d.count >= MAX_CW'(cfg_afull_thresh));
    if (wr_pushing) wr_adr_d = adr_inc(wr_adr_q);
    if (flush) begin
      wr_d     = '0;
      wr_adr_d = '0;
      afull_d  = (cfg_afull_thresh == '0);
    end
  end

  // Read side: rd_adr is the head entry; on a pop the next entry is fetched so pops stream.
  always_comb begin
    rd_count_d = rd_count_q + CW'(rd_pushing_q) - CW'(rd_popping);
    out_pvld_d = (rd_count_d != '0);
    ram_re     = out_pvld_d & (rd_popping | ~out_pvld_q);
    ram_ra     = rd_popping ? adr_inc(rd_adr_q) : rd_adr_q;
    rd_adr_d   = ram_ra;
    if (flush) begin
      rd_count_d = '0;
      out_pvld_d = 1'b0;
      ram_re     = 1'b0;
      rd_adr_d   = '0;
    end
  end

  // Write-side state and the pop crossing flop.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      wr_q         <= '0;
      wr_adr_q     <= '0;
      wr_popping_q <= 1'b0;
      afull_q      <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      wr_adr_q     <= wr_adr_d;
      wr_popping_q <= rd_popping & ~flush;
      afull_q      <= afull_d;
    end
  end

  // Read-side state and the push crossing flop.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      rd_pushing_q <= 1'b0;
      rd_adr_q     <= '0;
      rd_count_q   <= '0;
      out_pvld_q   <= 1'b0;
    end else begin
      rd_pushing_q <= ram_we;
      rd_adr_q     <= rd_adr_d;
      rd_count_q   <= rd_count_d;
      out_pvld_q   <= out_pvld_d;
    end
  end

  nvdla_fifo_ram_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk           (nvdla_core_clk),
    .we            (ram_we),
    .wa            (wr_adr_q),
    .di            (in_pd),
    .re            (ram_re),
    .ore           (ram_re),
    .ra            (ram_ra),
    .dout          (out_pd),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  assign in_prdy  = ~wr_q.busy;
  assign out_pvld = out_pvld_q;
  assign wr_count = CW'(wr_q.count);
  assign afull    = afull_q;

endmodule

// File: tb/tb_nvdla_sdp_param_cq.sv
// Scoreboard bench for nvdla_sdp_param_cq at DEPTH=80, WIDTH=14.
module tb_nvdla_sdp_param_cq;

  localparam int unsigned WIDTH = 14;
  localparam int unsigned DEPTH = 80;
  localparam int unsigned CW    = 7;

  logic              clk;
  logic              rst;
  logic              in_pvld;
  logic              in_prdy;
  logic [WIDTH-1:0]  in_pd;
  logic              out_pvld;
  logic              out_prdy;
  logic [WIDTH-1:0]  out_pd;
  logic [CW-1:0]     cfg_wr_limit;
  logic [CW-1:0]     cfg_afull_thresh;
  logic              flush;
  logic [CW-1:0]     wr_count;
  logic              afull;
  logic [31:0]       pwrbus_ram_pd;

  logic [WIDTH-1:0]  sb [$];
  int                n_checks;
  int                n_fail;
  int                max_cnt;

  nvdla_sdp_param_cq #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .in_pvld          (in_pvld),
    .in_prdy          (in_prdy),
    .in_pd            (in_pd),
    .out_pvld         (out_pvld),
    .out_prdy         (out_prdy),
    .out_pd           (out_pd),
    .cfg_wr_limit     (cfg_wr_limit),
    .cfg_afull_thresh (cfg_afull_thresh),
    .flush            (flush),
    .wr_count         (wr_count),
    .afull            (afull),
    .pwrbus_ram_pd    (pwrbus_ram_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pops compared against the oldest pushed payload; flush discards everything.
  always @(negedge clk) begin
    if (!rst) begin
      if (32'(wr_count) > max_cnt) max_cnt = 32'(wr_count);
      if (out_pvld && out_prdy) begin
        check("pop_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("pop_data", 32'(out_pd), 32'(sb.pop_front()));
      end
      if (flush) sb.delete();
      else if (in_pvld && in_prdy) sb.push_back(in_pd);
    end
  end

  task automatic drain_all(input string tag);
    int i;
    in_pvld  = 1'b0;
    out_prdy = 1'b1;
    i = 0;
    while ((sb.size() != 0 || out_pvld) && i < 400) begin
      tick();
      i++;
    end
    repeat (3) tick();
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_cnt_zero"}, 32'(wr_count), 32'd0);
    check({tag, "_prdy"}, 32'(in_prdy), 32'd1);
    out_prdy = 1'b0;
  endtask

  initial begin
    int pushed;
    int cyc;
    int n;
    n_checks = 0;
    n_fail = 0;
    max_cnt = 0;
    rst = 1'b1;
    in_pvld = 1'b0;
    in_pd = '0;
    out_prdy = 1'b0;
    flush = 1'b0;
    cfg_wr_limit = '0;
    cfg_afull_thresh = CW'(72);
    pwrbus_ram_pd = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_prdy", 32'(in_prdy), 32'd1);
    check("rst_pvld", 32'(out_pvld), 32'd0);
    check("rst_cnt", 32'(wr_count), 32'd0);
    check("rst_afull", 32'(afull), 32'd0);
    rst = 1'b0;
    tick();

    // Single push: visible two cycles later
    in_pvld = 1'b1; in_pd = 14'h1A5; out_prdy = 1'b1;
    tick();
    in_pvld = 1'b0;
    check("single_cnt1", 32'(wr_count), 32'd1);
    check("single_pvld_t1", 32'(out_pvld), 32'd0);
    tick();
    check("single_pvld_t2", 32'(out_pvld), 32'd1);
    check("single_pd_t2", 32'(out_pd), 32'h1A5);
    tick();
    check("single_pvld_t3", 32'(out_pvld), 32'd0);
    tick();
    check("single_cnt0", 32'(wr_count), 32'd0);
    out_prdy = 1'b0;
    tick();

    // Fill to full with the pop side stalled
    for (int i = 0; i < 80; i++) begin
      in_pvld = 1'b1;
      in_pd = 14'(i);
      check("fill_prdy", 32'(in_prdy), 32'd1);
      tick();
      check("fill_cnt", 32'(wr_count), 32'(i + 1));
      check("fill_afull", 32'(afull), 32'((i + 1) >= 72));
    end
    in_pvld = 1'b0;
    check("full_prdy", 32'(in_prdy), 32'd0);
    tick();
    check("stall_pvld", 32'(out_pvld), 32'd1);
    check("stall_pd", 32'(out_pd), 32'd0);
    tick();
    check("stall_pd_hold", 32'(out_pd), 32'd0);

    // Drain one per cycle in order
    out_prdy = 1'b1;
    for (int k = 0; k < 80; k++) begin
      check("drain_pvld", 32'(out_pvld), 32'd1);
      check("drain_pd", 32'(out_pd), 32'(k));
      if (k == 1) check("full_prdy_late", 32'(in_prdy), 32'd0);
      tick();
    end
    check("drain_pvld_end", 32'(out_pvld), 32'd0);
    repeat (3) tick();
    check("drain_cnt", 32'(wr_count), 32'd0);
    check("drain_prdy", 32'(in_prdy), 32'd1);
    out_prdy = 1'b0;

    // Random pop rate across pointer wrap
    pushed = 0;
    cyc = 0;
    while (pushed < 200 && cyc < 5000) begin
      in_pvld = 1'b1;
      in_pd = 14'($urandom);
      out_prdy = 1'($urandom_range(0, 1));
      if (in_prdy) pushed++;
      tick();
      cyc++;
    end
    check("wrap_pushed", 32'(pushed), 32'd200);
    drain_all("wrap");
    check("wrap_max_cnt", 32'(max_cnt <= 80), 32'd1);

    // Write limit 16
    cfg_wr_limit = CW'(16);
    in_pvld = 1'b1;
    for (int i = 0; i < 40 && in_prdy; i++) begin
      in_pd = 14'($urandom);
      tick();
    end
    in_pvld = 1'b0;
    check("limit16_cnt", 32'(wr_count), 32'd16);
    check("limit16_prdy", 32'(in_prdy), 32'd0);
    drain_all("limit16");

    // Lower the limit to 8 with 12 entries stored
    n = 0;
    while (n < 12) begin
      in_pvld = 1'b1;
      in_pd = 14'($urandom);
      if (in_prdy) n++;
      tick();
    end
    in_pvld = 1'b0;
    cfg_wr_limit = CW'(8);
    repeat (3) tick();
    check("limit8_cnt", 32'(wr_count), 32'd12);
    check("limit8_prdy", 32'(in_prdy), 32'd0);
    in_pvld = 1'b1;
    in_pd = 14'h0123;
    out_prdy = 1'b1;
    cyc = 0;
    while (!in_prdy && cyc < 40) begin
      tick();
      cyc++;
    end
    check("limit8_reopen", 32'(in_prdy), 32'd1);
    check("limit8_reopen_cnt", 32'(wr_count), 32'd7);
    drain_all("limit8");
    cfg_wr_limit = '0;

    // Flush at count 40 with a simultaneous push
    for (int i = 0; i < 40; i++) begin
      in_pvld = 1'b1;
      in_pd = 14'(i + 100);
      tick();
    end
    in_pvld = 1'b0;
    repeat (2) tick();
    check("flush_pre_cnt", 32'(wr_count), 32'd40);
    flush = 1'b1;
    in_pvld = 1'b1;
    in_pd = 14'h2AA;
    tick();
    flush = 1'b0;
    in_pvld = 1'b0;
    check("flush_cnt", 32'(wr_count), 32'd0);
    check("flush_pvld", 32'(out_pvld), 32'd0);
    check("flush_prdy", 32'(in_prdy), 32'd1);
    check("flush_afull", 32'(afull), 32'd0);
    in_pvld = 1'b1;
    in_pd = 14'h155;
    out_prdy = 1'b1;
    tick();
    in_pvld = 1'b0;
    tick();
    check("post_flush_pvld", 32'(out_pvld), 32'd1);
    check("post_flush_pd", 32'(out_pd), 32'h155);
    tick();
    check("post_flush_pvld_end", 32'(out_pvld), 32'd0);
    drain_all("flush");

    // Asynchronous reset mid-stream at count 25
    cfg_afull_thresh = CW'(20);
    for (int i = 0; i < 25; i++) begin
      in_pvld = 1'b1;
      in_pd = 14'(i + 300);
      tick();
    end
    in_pvld = 1'b0;
    repeat (2) tick();
    check("arst_pre_cnt", 32'(wr_count), 32'd25);
    check("arst_pre_afull", 32'(afull), 32'd1);
    check("arst_pre_pvld", 32'(out_pvld), 32'd1);
    in_pvld = 1'b1;
    in_pd = 14'h0777;
    @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check("arst_prdy", 32'(in_prdy), 32'd1);
    check("arst_pvld", 32'(out_pvld), 32'd0);
    check("arst_cnt", 32'(wr_count), 32'd0);
    check("arst_afull", 32'(afull), 32'd0);
    in_pvld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cfg_afull_thresh = CW'(72);
    tick();
    in_pvld = 1'b1;
    in_pd = 14'h3FF;
    out_prdy = 1'b1;
    tick();
    in_pvld = 1'b0;
    tick();
    check("arst_after_pvld", 32'(out_pvld), 32'd1);
    check("arst_after_pd", 32'(out_pd), 32'h3FF);
    drain_all("arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time bound so a stuck run still ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
